// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcode/funct encodings, ALU operation codes
// and the enumerations carried in the decoded control bundle.
// No ports (package).
package mips_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  // ALU operation codes
  localparam logic [3:0] ALU_SLL   = 4'd0;
  localparam logic [3:0] ALU_SRA   = 4'd1;
  localparam logic [3:0] ALU_SRL   = 4'd2;
  localparam logic [3:0] ALU_ADD   = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_AND   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_XOR   = 4'd9;
  localparam logic [3:0] ALU_NOR   = 4'd10;
  localparam logic [3:0] ALU_SLT   = 4'd11;
  localparam logic [3:0] ALU_SLTU  = 4'd12;
  localparam logic [3:0] ALU_OTHER = 4'd13;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_REGIMM
  } branch_e;

  typedef enum logic [1:0] {
    JUMP_NONE, JUMP_J, JUMP_JAL, JUMP_JR
  } jump_e;

  typedef enum logic [1:0] {
    MODE_BYTE, MODE_HALF, MODE_WORD
  } mode_e;

  typedef enum logic [2:0] {
    MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO
  } mdu_e;

  // Decoded control bundle (ALU code travels separately: its width is a parameter)
  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       signed_ext;
    logic       shift_var;
    logic       lui;
    logic       syscall;
    logic       illegal;
    branch_e    branch;
    jump_e      jump;
    mode_e      mode;
    mdu_e       mdu_op;
    logic [4:0] dest;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_pipe_if.sv
// ID-to-EX handshake and control-bundle bus.
// master: upstream/downstream environment (drives id_valid, id_instr, ex_ready, flush)
// slave : id_ctrl_pipe (drives id_ready, the ex_* bundle and mdu_busy)
interface id_ctrl_pipe_if #(
  parameter int ALU_OP_W = 4
);
  logic                id_valid;
  logic [31:0]         id_instr;
  logic                id_ready;
  logic                ex_ready;
  logic                flush;
  logic                ex_valid;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_mem_to_reg;
  logic                ex_mem_write;
  logic                ex_alu_src;
  logic                ex_reg_write;
  logic                ex_signed_ext;
  logic                ex_shift_var;
  logic                ex_lui;
  logic                ex_syscall;
  logic                ex_illegal;
  logic [2:0]          ex_branch;
  logic [1:0]          ex_jump;
  logic [1:0]          ex_mode;
  logic [2:0]          ex_mdu_op;
  logic [4:0]          ex_dest;
  logic                mdu_busy;

  modport master (
    output id_valid, id_instr, ex_ready, flush,
    input  id_ready, ex_valid, ex_alu_op, ex_mem_to_reg, ex_mem_write, ex_alu_src,
           ex_reg_write, ex_signed_ext, ex_shift_var, ex_lui, ex_syscall, ex_illegal,
           ex_branch, ex_jump, ex_mode, ex_mdu_op, ex_dest, mdu_busy
  );

  modport slave (
    input  id_valid, id_instr, ex_ready, flush,
    output id_ready, ex_valid, ex_alu_op, ex_mem_to_reg, ex_mem_write, ex_alu_src,
           ex_reg_write, ex_signed_ext, ex_shift_var, ex_lui, ex_syscall, ex_illegal,
           ex_branch, ex_jump, ex_mode, ex_mdu_op, ex_dest, mdu_busy
  );
endinterface

// File: rtl/id_decode.sv
// Purely combinational MIPS instruction decoder (shared with the single-cycle core).
// Ports: instr (in, 32) instruction word; alu_op (out, ALU_OP_W) ALU code;
//        ctrl (out) decoded control bundle; reads_rt (out) instruction reads rt.
module id_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 4,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic [31:0]         instr,
  output logic [ALU_OP_W-1:0] alu_op,
  output ctrl_t               ctrl,
  output logic                reads_rt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [3:0] alu_code;
  logic       illegal;
  logic       is_load;
  logic       is_store;
  logic       imm_op;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctrl      = '0;
    ctrl.mode = MODE_WORD;
    alu_code  = ALU_OTHER;
    reads_rt  = 1'b0;
    illegal   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    imm_op    = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt       = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          F_SLL:  alu_code = ALU_SLL;
          F_SRL:  alu_code = ALU_SRL;
          F_SRA:  alu_code = ALU_SRA;
          F_SLLV: begin alu_code = ALU_SLL; ctrl.shift_var = 1'b1; end
          F_SRLV: begin alu_code = ALU_SRL; ctrl.shift_var = 1'b1; end
          F_SRAV: begin alu_code = ALU_SRA; ctrl.shift_var = 1'b1; end
          F_JR:      begin ctrl.jump = JUMP_JR; ctrl.reg_write = 1'b0; end
          F_SYSCALL: begin ctrl.syscall = 1'b1; ctrl.reg_write = 1'b0; end
          F_MFHI:  begin ctrl.mdu_op = MDU_MFHI; illegal = !ENABLE_MDU; end
          F_MFLO:  begin ctrl.mdu_op = MDU_MFLO; illegal = !ENABLE_MDU; end
          F_MULT:  begin ctrl.mdu_op = MDU_MULT;  ctrl.reg_write = 1'b0; illegal = !ENABLE_MDU; end
          F_MULTU: begin ctrl.mdu_op = MDU_MULTU; ctrl.reg_write = 1'b0; illegal = !ENABLE_MDU; end
          F_DIV:   begin ctrl.mdu_op = MDU_DIV;   ctrl.reg_write = 1'b0; illegal = !ENABLE_MDU; end
          F_DIVU:  begin ctrl.mdu_op = MDU_DIVU;  ctrl.reg_write = 1'b0; illegal = !ENABLE_MDU; end
          F_ADD, F_ADDU: alu_code = ALU_ADD;
          F_SUB, F_SUBU: alu_code = ALU_SUB;
          F_AND:  alu_code = ALU_AND;
          F_OR:   alu_code = ALU_OR;
          F_XOR:  alu_code = ALU_XOR;
          F_NOR:  alu_code = ALU_NOR;
          F_SLT:  alu_code = ALU_SLT;
          F_SLTU: alu_code = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin ctrl.branch = BR_REGIMM; ctrl.signed_ext = 1'b1; end
      OP_J:      ctrl.jump = JUMP_J;
      OP_JAL:    begin ctrl.jump = JUMP_JAL; ctrl.reg_write = 1'b1; end
      OP_BEQ:    begin ctrl.branch = BR_BEQ;  ctrl.signed_ext = 1'b1; reads_rt = 1'b1; end
      OP_BNE:    begin ctrl.branch = BR_BNE;  ctrl.signed_ext = 1'b1; reads_rt = 1'b1; end
      OP_BLEZ:   begin ctrl.branch = BR_BLEZ; ctrl.signed_ext = 1'b1; end
      OP_BGTZ:   begin ctrl.branch = BR_BGTZ; ctrl.signed_ext = 1'b1; end
      OP_ADDI, OP_ADDIU: begin alu_code = ALU_ADD;  imm_op = 1'b1; ctrl.signed_ext = 1'b1; end
      OP_SLTI:   begin alu_code = ALU_SLT;  imm_op = 1'b1; ctrl.signed_ext = 1'b1; end
      OP_SLTIU:  begin alu_code = ALU_SLTU; imm_op = 1'b1; ctrl.signed_ext = 1'b1; end
      OP_ANDI:   begin alu_code = ALU_AND;  imm_op = 1'b1; end
      OP_ORI:    begin alu_code = ALU_OR;   imm_op = 1'b1; end
      OP_XORI:   begin alu_code = ALU_XOR;  imm_op = 1'b1; end
      OP_LUI:    begin alu_code = ALU_SLL;  imm_op = 1'b1; ctrl.lui = 1'b1; end
      OP_LB, OP_LBU: begin is_load = 1'b1;  ctrl.mode = MODE_BYTE; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  ctrl.mode = MODE_HALF; end
      OP_LW:         is_load = 1'b1;
      OP_SB:         begin is_store = 1'b1; ctrl.mode = MODE_BYTE; end
      OP_SH:         begin is_store = 1'b1; ctrl.mode = MODE_HALF; end
      OP_SW:         is_store = 1'b1;
      default:       illegal = 1'b1;
    endcase

    // Memory ops compute base + sign-extended offset
    if (is_load || is_store) begin
      alu_code        = ALU_ADD;
      ctrl.alu_src    = 1'b1;
      ctrl.signed_ext = 1'b1;
    end
    if (is_load) begin
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
    end
    if (is_store) begin
      ctrl.mem_write = 1'b1;
      reads_rt       = 1'b1;
    end
    if (imm_op) begin
      ctrl.alu_src   = 1'b1;
      ctrl.reg_write = 1'b1;
    end

    ctrl.dest = (ctrl.jump == JUMP_JAL) ? 5'd31 :
                (op == OP_RTYPE)        ? instr[15:11] : instr[20:16];

    // An illegal instruction must have no architectural side effects downstream
    if (illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      alu_code     = ALU_OTHER;
    end

    alu_op = ALU_OP_W'(alu_code);
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage control: decodes the ID instruction, registers the control bundle into
// the ID/EX boundary under a valid/ready handshake, detects load-use and MDU-busy
// hazards and tracks the multiply/divide busy window.
// Ports: clk (rising edge), rst_n (async active-low), bus (id_ctrl_pipe_if.slave).
module id_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter bit ENABLE_MDU  = 1'b1,
  parameter int ALU_OP_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  id_ctrl_pipe_if.slave bus
);

  logic [ALU_OP_W-1:0] dec_alu_op;
  ctrl_t               dec_ctrl;
  logic                dec_reads_rt;

  logic                ex_valid_reg;
  logic [ALU_OP_W-1:0] alu_op_reg;
  ctrl_t               ctrl_reg;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       load_use;
  logic       mdu_stall;
  logic       stall;
  logic       advance;
  logic       accept;
  logic       mdu_busy;

  id_decode #(
    .ALU_OP_W   (ALU_OP_W),
    .ENABLE_MDU (ENABLE_MDU)
  ) u_decode (
    .instr    (bus.id_instr),
    .alu_op   (dec_alu_op),
    .ctrl     (dec_ctrl),
    .reads_rt (dec_reads_rt)
  );

  assign id_rs = bus.id_instr[25:21];
  assign id_rt = bus.id_instr[20:16];

  // Load in EX whose result is needed by the ID instruction ($0 never hazards)
  assign load_use  = ex_valid_reg && ctrl_reg.mem_to_reg && (ctrl_reg.dest != 5'd0) &&
                     ((ctrl_reg.dest == id_rs) || (dec_reads_rt && (ctrl_reg.dest == id_rt)));
  assign mdu_stall = mdu_busy && (dec_ctrl.mdu_op != MDU_NONE);
  assign stall     = bus.id_valid && (load_use || mdu_stall);
  assign advance   = !ex_valid_reg || bus.ex_ready;
  assign accept    = bus.id_valid && !stall && advance && !bus.flush;

  assign bus.id_ready = !bus.flush && !stall && advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      alu_op_reg   <= '0;
      ctrl_reg     <= '0;
    end else if (bus.flush || (advance && !accept)) begin
      // Flush or bubble: slot emptied and bundle cleared
      ex_valid_reg <= 1'b0;
      alu_op_reg   <= '0;
      ctrl_reg     <= '0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      alu_op_reg   <= dec_alu_op;
      ctrl_reg     <= dec_ctrl;
    end
  end

  generate
    if (ENABLE_MDU) begin : g_mdu
      logic [3:0] mdu_cnt_reg;

      // Busy window restarts on the accepting edge of a mult/div; flush does not cancel it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mdu_cnt_reg <= 4'd0;
        end else if (accept && (dec_ctrl.mdu_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU})) begin
          mdu_cnt_reg <= 4'(MDU_LATENCY);
        end else if (mdu_cnt_reg != 4'd0) begin
          mdu_cnt_reg <= mdu_cnt_reg - 4'd1;
        end
      end

      assign mdu_busy = (mdu_cnt_reg != 4'd0);
    end else begin : g_no_mdu
      assign mdu_busy = 1'b0;
    end
  endgenerate

  assign bus.mdu_busy      = mdu_busy;
  assign bus.ex_valid      = ex_valid_reg;
  assign bus.ex_alu_op     = alu_op_reg;
  assign bus.ex_mem_to_reg = ctrl_reg.mem_to_reg;
  assign bus.ex_mem_write  = ctrl_reg.mem_write;
  assign bus.ex_alu_src    = ctrl_reg.alu_src;
  assign bus.ex_reg_write  = ctrl_reg.reg_write;
  assign bus.ex_signed_ext = ctrl_reg.signed_ext;
  assign bus.ex_shift_var  = ctrl_reg.shift_var;
  assign bus.ex_lui        = ctrl_reg.lui;
  assign bus.ex_syscall    = ctrl_reg.syscall;
  assign bus.ex_illegal    = ctrl_reg.illegal;
  assign bus.ex_branch     = ctrl_reg.branch;
  assign bus.ex_jump       = ctrl_reg.jump;
  assign bus.ex_mode       = ctrl_reg.mode;
  assign bus.ex_mdu_op     = ctrl_reg.mdu_op;
  assign bus.ex_dest       = ctrl_reg.dest;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Self-checking bench for id_ctrl_pipe: directed scenarios followed by random
// instruction traffic, all checked against a mnemonic-level reference model.
module tb_id_ctrl_pipe;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ctrl_pipe_if #(.ALU_OP_W(4)) bus();

  id_ctrl_pipe #(
    .MDU_LATENCY (LAT),
    .ENABLE_MDU  (1'b1),
    .ALU_OP_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int alu;
    bit m2r, mw, asrc, rw, sx, sv, lui, sys, ill;
    int br, jmp, mode, mdu, dest;
  } exp_t;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_until = 0;
  bit   m_valid = 0;
  exp_t m_b;
  logic last_ready;

  logic [5:0] r_functs [25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0C,
                                6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
  logic [5:0] opcs [25] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20,
                            6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h10};

  localparam logic [31:0] I_LW   = 32'h8C080000;  // lw  $8,0($0)
  localparam logic [31:0] I_ADD  = 32'h01084820;  // add $9,$8,$8
  localparam logic [31:0] I_MULT = 32'h01090018;  // mult $8,$9
  localparam logic [31:0] I_MFHI = 32'h00005010;  // mfhi $10
  localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_SW   = 32'hAC090004;  // sw $9,4($0)
  localparam logic [31:0] I_NOP  = 32'h00000000;

  // ---------------- reference model ----------------
  function automatic string mnem(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h00: return "sll";   6'h02: return "srl";   6'h03: return "sra";
        6'h04: return "sllv";  6'h06: return "srlv";  6'h07: return "srav";
        6'h08: return "jr";    6'h0C: return "syscall";
        6'h10: return "mfhi";  6'h12: return "mflo";  6'h18: return "mult";
        6'h19: return "multu"; 6'h1A: return "div";   6'h1B: return "divu";
        6'h20: return "add";   6'h21: return "addu";  6'h22: return "sub";
        6'h23: return "subu";  6'h24: return "and";   6'h25: return "or";
        6'h26: return "xor";   6'h27: return "nor";   6'h2A: return "slt";
        6'h2B: return "sltu";
        default: return "bad";
      endcase
    end
    case (i[31:26])
      6'h01: return "regimm"; 6'h02: return "j";     6'h03: return "jal";
      6'h04: return "beq";    6'h05: return "bne";   6'h06: return "blez";
      6'h07: return "bgtz";   6'h08: return "addi";  6'h09: return "addiu";
      6'h0A: return "slti";   6'h0B: return "sltiu"; 6'h0C: return "andi";
      6'h0D: return "ori";    6'h0E: return "xori";  6'h0F: return "lui";
      6'h20: return "lb";     6'h21: return "lh";    6'h23: return "lw";
      6'h24: return "lbu";    6'h25: return "lhu";   6'h28: return "sb";
      6'h29: return "sh";     6'h2B: return "sw";
      default: return "bad";
    endcase
  endfunction

  function automatic bit has(input string lst, input string m);
    string p;
    string k;
    p = {" ", lst, " "};
    k = {" ", m, " "};
    for (int i = 0; i + k.len() <= p.len(); i++)
      if (p.substr(i, i + k.len() - 1) == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t zero_exp();
    exp_t z;
    z.alu = 0; z.m2r = 0; z.mw = 0; z.asrc = 0; z.rw = 0; z.sx = 0; z.sv = 0;
    z.lui = 0; z.sys = 0; z.ill = 0; z.br = 0; z.jmp = 0; z.mode = 0; z.mdu = 0; z.dest = 0;
    return z;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t  e;
    string m;
    string mem;
    m   = mnem(i);
    mem = "lb lh lw lbu lhu sb sh sw";
    e   = zero_exp();
    if (m == "bad") begin
      e.ill = 1;
      e.alu = 13;
      return e;
    end
    e.alu  = has({"add addu addi addiu ", mem}, m) ? 5 :
             has("sll sllv lui", m) ? 0 : has("sra srav", m) ? 1 :
             has("srl srlv", m) ? 2 : has("sub subu", m) ? 6 :
             has("and andi", m) ? 7 : has("or ori", m) ? 8 :
             has("xor xori", m) ? 9 : (m == "nor") ? 10 :
             has("slt slti", m) ? 11 : has("sltu sltiu", m) ? 12 : 13;
    e.m2r  = has("lb lh lw lbu lhu", m);
    e.mw   = has("sb sh sw", m);
    e.asrc = has({"addi addiu slti sltiu andi ori xori lui ", mem}, m);
    e.rw   = !has("jr syscall mult multu div divu sb sh sw beq bne blez bgtz regimm j", m);
    e.sx   = has({"addi addiu slti sltiu beq bne blez bgtz regimm ", mem}, m);
    e.sv   = has("sllv srlv srav", m);
    e.lui  = (m == "lui");
    e.sys  = (m == "syscall");
    e.br   = (m == "beq") ? 1 : (m == "bne") ? 2 : (m == "blez") ? 3 :
             (m == "bgtz") ? 4 : (m == "regimm") ? 5 : 0;
    e.jmp  = (m == "j") ? 1 : (m == "jal") ? 2 : (m == "jr") ? 3 : 0;
    e.mode = has("lb lbu sb", m) ? 0 : has("lh lhu sh", m) ? 1 : 2;
    e.mdu  = (m == "mult") ? 1 : (m == "multu") ? 2 : (m == "div") ? 3 :
             (m == "divu") ? 4 : (m == "mfhi") ? 5 : (m == "mflo") ? 6 : 0;
    e.dest = (m == "jal") ? 31 : (i[31:26] == 6'h00) ? int'(i[15:11]) : int'(i[20:16]);
    return e;
  endfunction

  function automatic bit model_ready(input bit v, input logic [31:0] ins, input bit exr, input bit fl);
    string m;
    bit    rd_rt;
    bit    lu;
    bit    ms;
    m     = mnem(ins);
    rd_rt = (ins[31:26] == 6'h00) || has("beq bne sb sh sw", m);
    lu    = m_valid && m_b.m2r && (m_b.dest != 0) &&
            ((m_b.dest == int'(ins[25:21])) || (rd_rt && (m_b.dest == int'(ins[20:16]))));
    ms    = (cyc < busy_until) && has("mult multu div divu mfhi mflo", m);
    return !fl && !(v && (lu || ms)) && (!m_valid || exr);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs;
    logic [4:0] rt;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0)
      return {6'h00, rs, rt, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              r_functs[$urandom_range(0, 24)]};
    return {opcs[$urandom_range(0, 24)], rs, rt, 16'($urandom)};
  endfunction

  task automatic model_reset();
    m_valid    = 0;
    m_b        = zero_exp();
    busy_until = 0;
    cyc        = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ex_valid",      32'(bus.ex_valid),      32'(m_valid));
    check("mdu_busy",      32'(bus.mdu_busy),      32'(cyc < busy_until));
    check("ex_alu_op",     32'(bus.ex_alu_op),     m_b.alu);
    check("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m_b.m2r));
    check("ex_mem_write",  32'(bus.ex_mem_write),  32'(m_b.mw));
    check("ex_alu_src",    32'(bus.ex_alu_src),    32'(m_b.asrc));
    check("ex_reg_write",  32'(bus.ex_reg_write),  32'(m_b.rw));
    check("ex_signed_ext", 32'(bus.ex_signed_ext), 32'(m_b.sx));
    check("ex_shift_var",  32'(bus.ex_shift_var),  32'(m_b.sv));
    check("ex_lui",        32'(bus.ex_lui),        32'(m_b.lui));
    check("ex_syscall",    32'(bus.ex_syscall),    32'(m_b.sys));
    check("ex_illegal",    32'(bus.ex_illegal),    32'(m_b.ill));
    check("ex_branch",     32'(bus.ex_branch),     m_b.br);
    check("ex_jump",       32'(bus.ex_jump),       m_b.jmp);
    check("ex_mode",       32'(bus.ex_mode),       m_b.mode);
    check("ex_mdu_op",     32'(bus.ex_mdu_op),     m_b.mdu);
    check("ex_dest",       32'(bus.ex_dest),       m_b.dest);
  endtask

  // One clock cycle: apply inputs, check outputs and id_ready, advance the model.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit exr, input bit fl);
    bit exp_ready;
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.ex_ready = exr;
    bus.flush    = fl;
    #1;
    check_outputs();
    exp_ready  = model_ready(v, ins, exr, fl);
    last_ready = bus.id_ready;
    check("id_ready", 32'(bus.id_ready), 32'(exp_ready));
    if (fl) begin
      m_valid = 0;
      m_b     = zero_exp();
    end else if (exr || !m_valid) begin
      if (v && exp_ready) begin
        m_valid = 1;
        m_b     = ref_decode(ins);
        if (has("mult multu div divu", mnem(ins))) busy_until = cyc + 1 + LAT;
        $display("cyc %0d: accept %08h (%s) dest=%0d", cyc, ins, mnem(ins), m_b.dest);
      end else begin
        m_valid = 0;
        m_b     = zero_exp();
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalled;
    bus.id_valid = 1'b0;
    bus.id_instr = '0;
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: one bubble, then the dependent add issues
    cycle(1, I_LW, 1, 0);
    cycle(1, I_ADD, 1, 0);
    check("lu_stall_ready", 32'(last_ready), 0);
    check("lu_bubble_valid", 32'(bus.ex_valid), 0);
    cycle(1, I_ADD, 1, 0);
    check("lu_add_valid", 32'(bus.ex_valid), 1);
    check("lu_add_dest", 32'(bus.ex_dest), 9);
    check("lu_add_alu", 32'(bus.ex_alu_op), 5);

    // mult then mfhi: mfhi held while the MDU is busy
    cycle(1, I_MULT, 1, 0);
    check("mult_busy", 32'(bus.mdu_busy), 1);
    stalled = 0;
    for (int k = 0; k < 10; k++) begin
      bus.id_valid = 1'b1;
      bus.id_instr = I_MFHI;
      bus.ex_ready = 1'b1;
      bus.flush    = 1'b0;
      #1;
      if (bus.id_ready === 1'b1) break;
      stalled++;
      cycle(1, I_MFHI, 1, 0);
    end
    check("mfhi_stall_cycles", stalled, LAT);
    cycle(1, I_MFHI, 1, 0);
    check("mfhi_mdu_op", 32'(bus.ex_mdu_op), 5);
    check("mfhi_dest", 32'(bus.ex_dest), 10);

    // Illegal opcode
    cycle(1, I_BAD, 1, 0);
    check("bad_illegal", 32'(bus.ex_illegal), 1);
    check("bad_reg_write", 32'(bus.ex_reg_write), 0);
    check("bad_mem_write", 32'(bus.ex_mem_write), 0);
    check("bad_alu", 32'(bus.ex_alu_op), 13);

    // jal held while EX is not ready
    cycle(1, I_JAL, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, I_NOP, 0, 0);
      check("jal_hold_ready", 32'(last_ready), 0);
      check("jal_hold_jump", 32'(bus.ex_jump), 2);
      check("jal_hold_dest", 32'(bus.ex_dest), 31);
    end
    check("jal_reg_write", 32'(bus.ex_reg_write), 1);
    cycle(1, I_NOP, 1, 0);
    check("jal_release_ready", 32'(last_ready), 1);

    // Flush with a valid store
    cycle(1, I_SW, 1, 1);
    check("flush_ready", 32'(last_ready), 0);
    check("flush_valid", 32'(bus.ex_valid), 0);
    check("flush_mem_write", 32'(bus.ex_mem_write), 0);

    // Flush together with a load-use stall
    cycle(1, I_LW, 1, 0);
    cycle(1, I_ADD, 1, 1);
    check("flush_stall_valid", 32'(bus.ex_valid), 0);
    cycle(1, I_ADD, 1, 0);

    // Asynchronous reset while stalled with the MDU busy
    cycle(1, I_MULT, 1, 0);
    cycle(1, I_LW, 1, 0);
    bus.id_valid = 1'b1;
    bus.id_instr = I_ADD;
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b0;
    #1;
    check("rst_pre_stall", 32'(bus.id_ready), 0);
    check("rst_pre_busy", 32'(bus.mdu_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(bus.ex_valid), 0);
    check("rst_busy", 32'(bus.mdu_busy), 0);
    check("rst_dest", 32'(bus.ex_dest), 0);
    check("rst_m2r", 32'(bus.ex_mem_to_reg), 0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 300; n++)
      cycle($urandom_range(0, 7) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0);
    bus.id_valid = 1'b0;
    #1;
    check_outputs();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/id_ctrl_pipe.md
Name: id_ctrl_pipe

Overview:
Pipelined successor to the single-cycle MIPS control decoder. It decodes the 32-bit instruction in ID and registers a control bundle into the ID/EX boundary under a valid/ready handshake. It also detects load-use hazards, detects illegal instructions, and tracks a parametrised-latency multiply/divide unit (MDU) busy window. It sits between the IF/ID register and the EX stage.

Parameters:
MDU_LATENCY, 4, cycles the MDU stays busy after a MULT/MULTU/DIV/DIVU is accepted (1..15)
ENABLE_MDU, 1, 0 makes MDU opcodes decode as illegal and holds mdu_busy at 0
ALU_OP_W, 4, width of ALU operation code

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction present in ID
id_instr  in  32  instruction word
id_ready  out  1  ID instruction accepted this cycle
ex_ready  in  1  EX can take a new bundle
flush  in  1  kill ID/EX contents (branch/exception redirect)
ex_valid  out  1  bundle in ID/EX is valid
ex_alu_op  out  ALU_OP_W  ALU code
ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_signed_ext, ex_shift_var, ex_lui, ex_syscall, ex_illegal  out  1 each  control flags
ex_branch  out  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz/bgez (opcode 1)
ex_jump  out  2  0 none, 1 j, 2 jal, 3 jr
ex_mode  out  2  0 byte, 1 half, 2 word
ex_mdu_op  out  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo
ex_dest  out  5  write register: 31 for jal, rd for R-type, else rt
mdu_busy  out  1  MDU counter nonzero

Behaviour:
- Decode is combinational and uses the existing encoding. ALU codes: add/addu/addi/addiu/loads/stores 5; sll/sllv/lui 0; sra/srav 1; srl/srlv 2; sub/subu 6; and/andi 7; or/ori 8; xor/xori 9; nor 10; slt/slti 11; sltu/sltiu 12; other 13.
- Added decode: funct 0x10/0x12/0x18/0x19/0x1A/0x1B map to mfhi/mflo/mult/multu/div/divu. mfhi/mflo set reg_write. mult/multu/div/divu clear reg_write.
- Illegal: any opcode or R-type funct outside the supported set. The bundle carries ex_illegal=1 with reg_write=0, mem_write=0, jump=0, branch=0.
- Stall (combinational). stall=1 when id_valid and any of the following hold:
  - Load-use: ex_valid, ex_mem_to_reg, ex_dest!=0, and ex_dest equals rs, or equals rt when the ID instruction reads rt (R-type, beq/bne, stores).
  - mdu_busy and the ID instruction is any MDU op.
- id_ready = !stall && (!ex_valid || ex_ready).
- Register update each rising clk, in priority order:
  - flush: ex_valid<=0. The ID instruction is not accepted (id_ready forced 0).
  - Else if ex_ready or !ex_valid:
    - id_valid && !stall: load bundle, ex_valid<=1.
    - Otherwise: ex_valid<=0 (bubble).
  - Else: hold all outputs.
- MDU counter:
  - Loads MDU_LATENCY on the accepting edge of mult/multu/div/divu.
  - Otherwise decrements to 0 each cycle.
  - flush does not clear it.
- Latency: one cycle from acceptance to ex_valid.
- Reset (asynchronous): ex_valid=0, all bundle fields 0, ex_dest=0, counter 0, mdu_busy=0. Reset asserted mid-stall drops the pending bundle.
- Simultaneous flush and stall: flush wins, ex_valid=0.

Decomposition:
- Shared package mips_ctrl_pkg: opcode/funct constants, ALU_OP codes, branch/jump/mode/mdu_op enumerations.
- Sub-module id_decode: purely combinational instr→bundle, reused by the single-cycle core.
- id_ctrl_pipe holds the hazard logic, handshake, pipeline register and MDU counter.

Test Plan:
- lw $8,0($0) (0x8C080000) then add $9,$8,$8 (0x01084820), ex_ready=1 → one bubble cycle (ex_valid=0), add issues next cycle with ex_dest=9, ex_alu_op=5.
- mult $8,$9 (0x01090018) then mfhi $10 (0x00005010), MDU_LATENCY=4 → mdu_busy high 4 cycles, mfhi held with id_ready=0 until counter reaches 0, then ex_mdu_op=5, ex_dest=10.
- Opcode 0x3F (0xFC000000) → ex_illegal=1, ex_reg_write=0, ex_mem_write=0, ex_alu_op=13.
- jal (0x0C000010) with ex_ready=0 for 3 cycles → bundle held stable, id_ready=0; on release ex_jump=2, ex_dest=31, ex_reg_write=1.
- flush asserted together with a valid sw → ex_valid=0 next cycle, ex_mem_write=0, id_ready=0.
- rst_n low mid-stall → all outputs 0 immediately, asynchronously.
